// File: rtl/rfc_pkg.sv
// Shared definitions for the readout frame controller: FSM encoding,
// FIFO word flag positions and the default frame geometry.
package rfc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        CAPT = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam int DW_DEF        = 16;
    localparam int FRAME_LEN_DEF = 48;

    function automatic int sof_pos(input int dw);
        return dw + 1;
    endfunction

    function automatic int eof_pos(input int dw);
        return dw;
    endfunction

    localparam int SOF_POS = sof_pos(DW_DEF);
    localparam int EOF_POS = eof_pos(DW_DEF);

endpackage

// File: rtl/rfc_frame_counter.sv
// In-frame word counter and SR alignment decode; the count restarts at
// zero whenever the controller does not explicitly advance it.
module rfc_frame_counter
    import rfc_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int WCNT_W    = $clog2(FRAME_LEN)
) (
    input  logic CLK,
    input  logic RST,
    input  logic adv,
    input  logic sr,
    output logic first,
    output logic last,
    output logic sr_early,
    output logic sr_missing,
    output logic frame_ok
);

    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(FRAME_LEN - 1);

    logic [WCNT_W-1:0] wcnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wcnt <= '0;
        end else if (adv) begin
            wcnt <= wcnt + WCNT_W'(1);
        end else begin
            wcnt <= '0;
        end
    end

    assign first      = (wcnt == '0);
    assign last       = (wcnt == LAST_IDX);
    assign frame_ok   = sr && last;
    assign sr_early   = sr && !last;
    assign sr_missing = !sr && last;

endmodule

// File: rtl/readout_frame_ctrl.sv
// Run controller between the free-running pixel source and the readout FIFO:
// frame alignment, SOF/EOF tagging, stop/overflow/timeout handling and stats.
module readout_frame_ctrl
    import rfc_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DW        = DW_DEF,
    parameter int TMO_CYC   = 96
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RUN_START,
    input  logic          RUN_STOP,
    input  logic [15:0]   NFRAMES,
    input  logic [DW-1:0] DATA_IN,
    input  logic          SR_IN,
    input  logic          FIFO_FULL,
    input  logic          CLR_ERR,
    output logic [DW+1:0] FIFO_DOUT,
    output logic          FIFO_WR,
    output logic          BUSY,
    output logic [15:0]   FRAMES_DONE,
    output logic [15:0]   DROP_CNT,
    output logic          ERR_OVF,
    output logic          ERR_LEN,
    output logic          ERR_TMO
);

    localparam int            TW       = $clog2(TMO_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t        state, state_n;
    logic [15:0]   nframes_q;
    logic          stop_pend, stop_n, stop_req;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          adv, wr_n, sof_n, eof_n;
    logic          start_ev, fd_inc, ovf_ev, len_ev, tmo_ev;
    logic          first, last, sr_early, sr_missing, frame_ok;

    rfc_frame_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .adv        (adv),
        .sr         (SR_IN),
        .first      (first),
        .last       (last),
        .sr_early   (sr_early),
        .sr_missing (sr_missing),
        .frame_ok   (frame_ok)
    );

    always_comb begin
        state_n  = state;
        stop_n   = stop_pend;
        stop_req = stop_pend || RUN_STOP;
        tcnt_n   = '0;
        adv      = 1'b0;
        wr_n     = 1'b0;
        sof_n    = 1'b0;
        eof_n    = 1'b0;
        start_ev = 1'b0;
        fd_inc   = 1'b0;
        ovf_ev   = 1'b0;
        len_ev   = 1'b0;
        tmo_ev   = 1'b0;
        unique case (state)
            IDLE: begin
                // A stop arriving with the start is remembered so exactly one frame is taken.
                stop_n = RUN_START && RUN_STOP;
                if (RUN_START) begin
                    start_ev = 1'b1;
                    state_n  = SYNC;
                end
            end
            SYNC: begin
                if (RUN_STOP) begin
                    state_n = IDLE;
                end else if (SR_IN) begin
                    state_n = CAPT;
                end else if (tcnt == TMO_LAST) begin
                    tmo_ev  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            CAPT: begin
                stop_n = stop_req;
                if (FIFO_FULL) begin
                    // SR on the lost word already marks the next boundary, so no DROP detour.
                    ovf_ev  = 1'b1;
                    state_n = SR_IN ? CAPT : DROP;
                end else begin
                    wr_n  = 1'b1;
                    sof_n = first;
                    eof_n = SR_IN || last;
                    if (frame_ok) begin
                        fd_inc = 1'b1;
                        if (stop_req || (nframes_q != 16'd0 && FRAMES_DONE + 16'd1 == nframes_q))
                            state_n = IDLE;
                    end else if (sr_early) begin
                        len_ev = 1'b1;
                        if (stop_req)
                            state_n = IDLE;
                    end else if (sr_missing) begin
                        len_ev  = 1'b1;
                        state_n = stop_req ? IDLE : SYNC;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            DROP: begin
                if (stop_req) begin
                    state_n = IDLE;
                end else if (SR_IN) begin
                    state_n = CAPT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            stop_pend   <= 1'b0;
            tcnt        <= '0;
            nframes_q   <= '0;
            FIFO_WR     <= 1'b0;
            FIFO_DOUT   <= '0;
            FRAMES_DONE <= '0;
            DROP_CNT    <= '0;
            ERR_OVF     <= 1'b0;
            ERR_LEN     <= 1'b0;
            ERR_TMO     <= 1'b0;
        end else begin
            state     <= state_n;
            stop_pend <= stop_n;
            tcnt      <= tcnt_n;
            FIFO_WR   <= wr_n;
            FIFO_DOUT <= {sof_n, eof_n, DATA_IN};
            if (start_ev) begin
                nframes_q   <= NFRAMES;
                FRAMES_DONE <= '0;
            end else if (fd_inc) begin
                FRAMES_DONE <= FRAMES_DONE + 16'd1;
            end
            // Clear is applied first so a same-cycle error event survives it.
            ERR_OVF <= (ERR_OVF && !CLR_ERR) || ovf_ev;
            ERR_LEN <= (ERR_LEN && !CLR_ERR) || len_ev;
            ERR_TMO <= (ERR_TMO && !CLR_ERR) || tmo_ev;
            if (ovf_ev)
                DROP_CNT <= sat_inc16(CLR_ERR ? 16'd0 : DROP_CNT);
            else if (CLR_ERR)
                DROP_CNT <= '0;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_readout_frame_ctrl.sv
// Directed bench for readout_frame_ctrl: a table of run scenarios on a
// generated 48-word frame stream plus hand-written timeout/reset sequences.
module tb_readout_frame_ctrl;
    import rfc_pkg::*;

    localparam int FL        = 48;
    localparam int DW        = 16;
    localparam int TMO       = 96;
    localparam int START_POS = 5;
    localparam int RUN_CYC   = 240;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RUN_START = 1'b0;
    logic          RUN_STOP = 1'b0;
    logic [15:0]   NFRAMES = '0;
    logic [DW-1:0] DATA_IN = '0;
    logic          SR_IN = 1'b0;
    logic          FIFO_FULL = 1'b0;
    logic          CLR_ERR = 1'b0;
    logic [DW+1:0] FIFO_DOUT;
    logic          FIFO_WR;
    logic          BUSY;
    logic [15:0]   FRAMES_DONE;
    logic [15:0]   DROP_CNT;
    logic          ERR_OVF, ERR_LEN, ERR_TMO;

    readout_frame_ctrl #(.FRAME_LEN(FL), .DW(DW), .TMO_CYC(TMO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RUN_START   (RUN_START),
        .RUN_STOP    (RUN_STOP),
        .NFRAMES     (NFRAMES),
        .DATA_IN     (DATA_IN),
        .SR_IN       (SR_IN),
        .FIFO_FULL   (FIFO_FULL),
        .CLR_ERR     (CLR_ERR),
        .FIFO_DOUT   (FIFO_DOUT),
        .FIFO_WR     (FIFO_WR),
        .BUSY        (BUSY),
        .FRAMES_DONE (FRAMES_DONE),
        .DROP_CNT    (DROP_CNT),
        .ERR_OVF     (ERR_OVF),
        .ERR_LEN     (ERR_LEN),
        .ERR_TMO     (ERR_TMO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int nframes, stop_f, stop_w, full_f, full_lo, full_hi, inj_f, inj_w;
        int writes, sofs, eofs, fd, drops, ovf, len, tmo;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int gpos = 0;
    int gframe = 0;
    logic sr_mask = 1'b0;
    logic sr_inj = 1'b0;
    logic [DW+1:0] wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW+1:0] mk(input logic sof, input logic eof, input int f, input int p);
        logic [DW+1:0] w;
        w = '0;
        w[SOF_POS] = sof;
        w[EOF_POS] = eof;
        w[15:8] = f[7:0];
        w[7:0]  = p[7:0];
        return w;
    endfunction

    // One source word per clock; data = {frame number, word position}.
    task automatic cycle();
        DATA_IN = {gframe[7:0], gpos[7:0]};
        SR_IN   = ((gpos == FL - 1) && !sr_mask) || sr_inj;
        @(posedge CLK);
        #1;
        if (FIFO_WR === 1'b1) wlog.push_back(FIFO_DOUT);
        if (gpos == FL - 1) begin
            gpos = 0;
            gframe++;
        end else begin
            gpos++;
        end
    endtask

    task automatic clear_ctrl();
        RUN_START = 1'b0;
        RUN_STOP  = 1'b0;
        FIFO_FULL = 1'b0;
        CLR_ERR   = 1'b0;
        sr_inj    = 1'b0;
    endtask

    task automatic do_reset();
        clear_ctrl();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
    endtask

    task automatic idle_to(input int pos);
        for (int c = 0; c < FL && gpos != pos; c++) cycle();
    endtask

    task automatic run_vec(input vec_t v, input string tag, output int f0);
        int s, e;
        idle_to(START_POS);
        f0 = gframe;
        wlog.delete();
        NFRAMES = 16'(v.nframes);
        for (int c = 0; c < RUN_CYC; c++) begin
            int rf;
            rf = gframe - f0;
            RUN_START = (c == 0);
            RUN_STOP  = (rf == v.stop_f) && (gpos == v.stop_w);
            FIFO_FULL = (rf == v.full_f) && (gpos >= v.full_lo) && (gpos <= v.full_hi);
            sr_inj    = (rf == v.inj_f) && (gpos == v.inj_w);
            cycle();
        end
        clear_ctrl();
        s = 0;
        e = 0;
        foreach (wlog[k]) begin
            s += int'(wlog[k][SOF_POS]);
            e += int'(wlog[k][EOF_POS]);
        end
        chk({tag, ".writes"}, 32'(wlog.size()), 32'(v.writes));
        chk({tag, ".sofs"}, 32'(s), 32'(v.sofs));
        chk({tag, ".eofs"}, 32'(e), 32'(v.eofs));
        chk({tag, ".frames_done"}, 32'(FRAMES_DONE), 32'(v.fd));
        chk({tag, ".drop_cnt"}, 32'(DROP_CNT), 32'(v.drops));
        chk({tag, ".err_ovf"}, 32'(ERR_OVF), 32'(v.ovf));
        chk({tag, ".err_len"}, 32'(ERR_LEN), 32'(v.len));
        chk({tag, ".err_tmo"}, 32'(ERR_TMO), 32'(v.tmo));
        chk({tag, ".busy_end"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        vec_t vt[7];
        vec_t realign;
        string names[7];
        int f0, bad;

        //        nfr stopF stopW fullF lo  hi  injF injW | wr  sof eof fd drp ovf len tmo
        vt[0] = '{2,  -1,   0,    -1,   0,  0,  -1,  0,    96,  2,  2,  2, 0,  0,  0,  0};
        vt[1] = '{0,   3,   20,   -1,   0,  0,  -1,  0,    144, 3,  3,  3, 0,  0,  0,  0};
        vt[2] = '{2,  -1,   0,    -1,   0,  0,   1,  30,   144, 4,  4,  2, 0,  0,  1,  0};
        vt[3] = '{0,   0,   5,    -1,   0,  0,  -1,  0,    48,  1,  1,  1, 0,  0,  0,  0};
        vt[4] = '{0,   0,   10,   -1,   0,  0,  -1,  0,    0,   0,  0,  0, 0,  0,  0,  0};
        vt[5] = '{2,  -1,   0,     1,   10, 12, -1,  0,    106, 3,  2,  2, 1,  1,  0,  0};
        vt[6] = '{2,  -1,   0,     1,   47, 47, -1,  0,    143, 3,  2,  2, 1,  1,  0,  0};
        realign = '{1, -1,  0,    -1,   0,  0,  -1,  0,    48,  1,  1,  1, 0,  0,  0,  0};
        names = '{"nfr2", "stop_f3", "sr_inj", "start_stop", "stop_sync", "ovf_mid", "ovf_last"};

        do_reset();
        chk("rst.fifo_wr", 32'(FIFO_WR), 32'd0);
        chk("rst.fifo_dout", 32'(FIFO_DOUT), 32'd0);
        chk("rst.busy", 32'(BUSY), 32'd0);
        chk("rst.frames_done", 32'(FRAMES_DONE), 32'd0);
        chk("rst.drop_cnt", 32'(DROP_CNT), 32'd0);
        chk("rst.errs", 32'({ERR_OVF, ERR_LEN, ERR_TMO}), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_vec(vt[i], names[i], f0);
            if (i == 0) begin
                chk("nfr2.w0", 32'(wlog[0]), 32'(mk(1, 0, f0 + 1, 0)));
                chk("nfr2.w47", 32'(wlog[47]), 32'(mk(0, 1, f0 + 1, 47)));
                chk("nfr2.w48", 32'(wlog[48]), 32'(mk(1, 0, f0 + 2, 0)));
                chk("nfr2.w95", 32'(wlog[95]), 32'(mk(0, 1, f0 + 2, 47)));
            end else if (i == 2) begin
                chk("sr_inj.w30", 32'(wlog[30]), 32'(mk(0, 1, f0 + 1, 30)));
                chk("sr_inj.w31", 32'(wlog[31]), 32'(mk(1, 0, f0 + 1, 31)));
                chk("sr_inj.w47", 32'(wlog[47]), 32'(mk(0, 1, f0 + 1, 47)));
                chk("sr_inj.w48", 32'(wlog[48]), 32'(mk(1, 0, f0 + 2, 0)));
            end else if (i == 5) begin
                chk("ovf_mid.w9", 32'(wlog[9]), 32'(mk(0, 0, f0 + 1, 9)));
                chk("ovf_mid.w10", 32'(wlog[10]), 32'(mk(1, 0, f0 + 2, 0)));
            end else if (i == 6) begin
                chk("ovf_last.w46", 32'(wlog[46]), 32'(mk(0, 0, f0 + 1, 46)));
                chk("ovf_last.w47", 32'(wlog[47]), 32'(mk(1, 0, f0 + 2, 0)));
            end
        end

        // CLR_ERR after the overflow run clears flags and the drop counter.
        CLR_ERR = 1'b1;
        cycle();
        CLR_ERR = 1'b0;
        chk("clr.err_ovf", 32'(ERR_OVF), 32'd0);
        chk("clr.drop_cnt", 32'(DROP_CNT), 32'd0);

        // Timeout: SR suppressed, CLR_ERR coincides with the timeout edge.
        do_reset();
        sr_mask = 1'b1;
        idle_to(START_POS);
        wlog.delete();
        NFRAMES = 16'd1;
        RUN_START = 1'b1;
        cycle();
        RUN_START = 1'b0;
        chk("tmo.busy_rise", 32'(BUSY), 32'd1);
        bad = 0;
        for (int k = 1; k < TMO; k++) begin
            cycle();
            if (BUSY !== 1'b1 || ERR_TMO !== 1'b0) bad++;
        end
        chk("tmo.early", 32'(bad), 32'd0);
        CLR_ERR = 1'b1;
        cycle();
        CLR_ERR = 1'b0;
        chk("tmo.err_tmo", 32'(ERR_TMO), 32'd1);
        chk("tmo.busy", 32'(BUSY), 32'd0);
        chk("tmo.no_writes", 32'(wlog.size()), 32'd0);
        sr_mask = 1'b0;

        // Reset mid-run at word 25 of captured frame 2, then realign.
        do_reset();
        idle_to(START_POS);
        f0 = gframe;
        NFRAMES = 16'd0;
        RUN_START = 1'b1;
        cycle();
        RUN_START = 1'b0;
        for (int c = 0; c < 400 && !((gframe - f0 == 2) && (gpos == 25)); c++) cycle();
        chk("mrst.fd_before", 32'(FRAMES_DONE), 32'd1);
        chk("mrst.wr_before", 32'(FIFO_WR), 32'd1);
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        chk("mrst.fifo_wr", 32'(FIFO_WR), 32'd0);
        chk("mrst.fifo_dout", 32'(FIFO_DOUT), 32'd0);
        chk("mrst.busy", 32'(BUSY), 32'd0);
        chk("mrst.frames_done", 32'(FRAMES_DONE), 32'd0);
        cycle();
        chk("mrst.wr_after", 32'(FIFO_WR), 32'd0);
        run_vec(realign, "realign", f0);
        chk("realign.w0", 32'(wlog[0]), 32'(mk(1, 0, f0 + 1, 0)));
        chk("realign.w47", 32'(wlog[47]), 32'(mk(0, 1, f0 + 1, 47)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/readout_frame_ctrl.md
# readout_frame_ctrl

Run controller between the free-running pixel data source (16-bit words, one per CLK, with a one-cycle SR pulse on the last word of each frame) and the readout FIFO. It arms on a software start, aligns to a frame boundary, and forwards whole frames tagged with start-of-frame and end-of-frame flags. It stops after a programmed frame count or on a stop command, drops frames under FIFO back-pressure and flags framing errors. The source never stalls, so the block never stalls it.

## Interface
- FRAME_LEN, 48: words per frame, SR coincident with word FRAME_LEN-1.
- DW, 16: data word width.
- TMO_CYC, 96: maximum cycles spent in SYNC waiting for SR.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high; clock CLK.
- RUN_START  in  1  one-cycle pulse; starts a run from IDLE.
- RUN_STOP  in  1  one-cycle pulse; requests a graceful stop.
- NFRAMES  in  16  frames per run; 0 means continuous. Sampled on RUN_START.
- DATA_IN  in  DW  source data word.
- SR_IN  in  1  high with the last word of a frame.
- FIFO_FULL  in  1  FIFO cannot accept a write on the next cycle.
- CLR_ERR  in  1  pulse; clears the sticky error flags and DROP_CNT.
- FIFO_DOUT  out  DW+2  {SOF, EOF, data}; reset value 0.
- FIFO_WR  out  1  write strobe; reset value 0.
- BUSY  out  1  high whenever the state is not IDLE; reset value 0.
- FRAMES_DONE  out  16  frames fully written in the current run. Cleared on RUN_START; reset value 0.
- DROP_CNT  out  16  frames dropped. Saturates at 0xFFFF; reset value 0.
- ERR_OVF, ERR_LEN, ERR_TMO  out  1 each  sticky error flags; reset value 0.

## Operation
- States are IDLE, SYNC, CAPT and DROP.
- IDLE:
  - RUN_START latches NFRAMES, clears FRAMES_DONE and the word counter, and moves to SYNC.
  - RUN_STOP is ignored in IDLE.
- SYNC:
  - Input words are discarded.
  - SR_IN moves to CAPT; the next cycle's word is word 0.
  - If TMO_CYC cycles pass without SR_IN, set ERR_TMO and go to IDLE.
- CAPT:
  - Every word is written. Word 0 carries SOF=1.
  - The word with SR_IN carries EOF=1 and increments FRAMES_DONE.
  - The word counter wcnt is 6 bits wide, sized clog2(FRAME_LEN).
- Length error:
  - Case 1: SR_IN arrives with wcnt != FRAME_LEN-1.
  - Case 2: wcnt reaches FRAME_LEN-1 without SR_IN.
  - In both cases set ERR_LEN and write that word with EOF=1.
  - Case 1: FRAMES_DONE is not incremented; stay in CAPT, and the next word is word 0.
  - Case 2: go to SYNC.
- Overflow in CAPT:
  - A word that must be written while FIFO_FULL=1 is not written.
  - Set ERR_OVF, increment DROP_CNT, go to DROP.
  - The consumer discards any SOF that is not followed by an EOF.
- DROP: discard words until SR_IN, then go to CAPT.
- End of frame:
  - After an EOF with NFRAMES≠0 and FRAMES_DONE equal to NFRAMES, go to IDLE.
  - After an EOF with a pending stop, go to IDLE.
- Stop:
  - RUN_STOP received in CAPT sets stop_pend. The current frame completes, then the block goes to IDLE.
  - RUN_STOP received in SYNC or DROP goes to IDLE on the next cycle.
- Simultaneous events:
  - RUN_START and RUN_STOP in the same cycle in IDLE: the start wins, and stop_pend is set.
  - SR_IN together with FIFO_FULL on the last word: the frame is dropped, EOF is not written, and the next state is CAPT.
  - CLR_ERR together with a new error event: the new error wins.

## Timing
- Input to output latency is 1 cycle: the word sampled at edge t appears on FIFO_DOUT/FIFO_WR after edge t+1.
- FIFO_FULL is evaluated at the same edge as its word.
- The sustained throughput is 1 word/cycle and there are no gap cycles.
- BUSY rises the cycle after RUN_START. It falls the cycle after the last EOF write is issued.
- RST mid-run:
  - All outputs and counters return to reset values on the next edge.
  - FIFO_WR is low from that edge on.
  - No flush and no EOF are written.

## Structure
- Shared package rfc_pkg holds the state encoding (IDLE=0, SYNC=1, CAPT=2, DROP=3), the SOF/EOF bit positions (DW+1, DW), and FRAME_LEN_DEF=48.
- Natural sub-module: rfc_frame_counter, which holds wcnt, SR alignment checks and the length-error decode.
- The FSM, the output register and the statistics stay in the top module.

## Test plan
- Start with NFRAMES=2 on the 48-word generator stream: after the first SR, exactly 96 writes with SOF on words 0/48 and EOF on words 47/95; FRAMES_DONE=2; BUSY drops; no errors.
- NFRAMES=0 with RUN_STOP at word 20 of frame 3: frame 3 completes through its EOF; 144 writes total after alignment; BUSY drops 1 cycle later.
- FIFO_FULL held high for words 10-12 of frame 1: frame 1 truncated at word 9 with no EOF; ERR_OVF=1; DROP_CNT=1; frame 2 written complete.
- SR_IN injected at word 30: word 30 written with EOF; ERR_LEN=1; next word carries SOF; FRAMES_DONE unchanged.
- SR_IN held low after start: ERR_TMO=1 and BUSY=0 exactly 96 cycles after entering SYNC; FIFO_WR never asserted.
- RST asserted at word 25: FIFO_WR=0 and all outputs are zero on the next edge; a new RUN_START realigns correctly.
